stage_seq: RTL
==============

# stage_seq

Parametrised multi-cycle instruction sequencer for the core. It drives a one-hot chain of N_STAGES unit enables, such as IFU/IDU/EXU/MEM/WB, and advances on per-stage finish handshakes. Beyond plain sequencing, it adds:
- halt and resume at instruction boundaries,
- pipeline flush,
- a per-stage watchdog with a fault state,
- a retired-instruction counter.

It sits at the top of the core between the stage units and the debug/interrupt logic.

## Interface
- N_STAGES, default 3: number of sequenced stages, legal range 2..8.
- TIMEOUT, default 255: maximum enabled cycles per stage before fault. 0 disables the watchdog.
- CNT_W, default 32: width of the retired-instruction counter.
- SW (localparam) = max(1, clog2(N_STAGES)).

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_finish  in  N_STAGES  per-stage done; bit k is sampled only while stage k is enabled.
- i_halt_req  in  1  level request to stop at the next instruction boundary.
- i_resume  in  1  leave HALTED.
- i_flush  in  1  abort the current instruction and restart at stage 0.
- o_en  out  N_STAGES  one-hot stage enable (registered).
- o_stage  out  SW  index of the current or last stage.
- o_state  out  2  0 BOOT, 1 RUN, 2 HALTED, 3 FAULT.
- o_retire  out  1  one-cycle pulse per completed instruction.
- o_retire_cnt  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.
- o_fault_stage  out  SW  stage index captured on watchdog fault.

## Operation
- Reset values: o_state=BOOT, o_en=0, o_stage=0, o_retire=0, o_retire_cnt=0, o_fault_stage=0, watchdog=0.
- Reset asserted mid-operation overrides everything on that edge.

BOOT (lasts exactly one cycle after reset release):
- If i_halt_req=1, go to HALTED with o_en=0.
- Otherwise go to RUN with o_stage=0 and o_en=1<<0.

RUN, stage k. Priority per edge is flush > watchdog > finish:
- **Flush** (i_flush=1): o_stage=0, o_en=1<<0, watchdog=0, no retire.
- **Watchdog fault** (TIMEOUT!=0, watchdog==TIMEOUT-1, and i_finish[k]=0): go to FAULT, o_en=0, o_fault_stage=k.
- **Finish, not last stage** (i_finish[k]=1, k<N_STAGES-1): o_stage=k+1, o_en=1<<(k+1), watchdog=0.
- **Finish, last stage** (i_finish[k]=1, k=N_STAGES-1):
  - o_retire=1 for the next cycle and o_retire_cnt increments.
  - If i_halt_req=1, go to HALTED, o_en=0, o_stage=0.
  - Otherwise o_stage=0, o_en=1<<0.
- **None of the above:** watchdog increments, saturating at TIMEOUT-1.
- i_finish bits of non-enabled stages are ignored in all states.

HALTED:
- o_en=0.
- i_resume=1: go to RUN at stage 0, watchdog=0. Resume wins over a simultaneous i_halt_req; halt is re-evaluated at the next boundary.
- i_flush is ignored.

FAULT:
- o_en=0, sticky.
- Exit only via i_rst, or via i_flush, which goes to RUN at stage 0 with watchdog=0.
- o_fault_stage holds its value until the next fault or reset.
- i_resume is ignored.

Invariants:
- o_en is exactly one-hot in RUN and all-zero otherwise.
- o_stage is always < N_STAGES.

## Timing
- o_en and o_state change on the same edge that samples i_finish, so there is zero bubble between stages.
- A stage asserting finish on its first enabled cycle therefore costs one cycle.
- Minimum instruction length is N_STAGES cycles.
- The watchdog counts enabled cycles of the current stage starting at 0. Finish on the TIMEOUT-th enabled cycle is accepted; its absence faults at that edge.
- o_retire is high in the cycle after the last-stage finish edge. o_retire_cnt shows the new value in that same cycle.
- Halt latency: at most one instruction; the request must be high at the last-stage finish edge.
- Resume to o_en[0] high: 1 cycle.

## Test plan
- Basic sequence, N_STAGES=3, each stage finishes on its first enabled cycle: o_en goes 001,010,100,001… each cycle; o_retire pulses every 3rd cycle; o_retire_cnt=4 after 12 run cycles.
- Halt/resume: raise i_halt_req during stage 1. The instruction completes (o_retire=1, o_state=2, o_en=0). Pulse i_resume, and on the next cycle o_en=001, o_state=1.
- Flush with simultaneous last-stage finish: o_en=001 on the next cycle, no o_retire, and o_retire_cnt unchanged.
- Watchdog, TIMEOUT=4: stage 2 never finishes, and o_state=3 with o_fault_stage=2 after 4 enabled cycles. Repeat with finish on the 4th cycle: no fault. Then pulse i_flush from FAULT and check o_state=1 with o_en=001.
- Counter wrap, CNT_W=4: 17 instructions give o_retire_cnt=1. Finish bits on inactive stages are ignored.
- N_STAGES=5, TIMEOUT=0, random finish delays up to 300 cycles: o_en is always one-hot, there is never a fault, and the retire count matches the scoreboard. Apply i_rst mid-stage 3 and check all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/stage_seq.sv
// Multi-cycle instruction sequencer: walks a one-hot enable chain across the core's
// stage units, with boundary halt/resume, flush, per-stage watchdog and retire counter.
module stage_seq #(
    parameter int  N_STAGES = 3,
    parameter int  TIMEOUT  = 255,
    parameter int  CNT_W    = 32,
    localparam int SW       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_STAGES-1:0] i_finish,
    input  logic                i_halt_req,
    input  logic                i_resume,
    input  logic                i_flush,
    output logic [N_STAGES-1:0] o_en,
    output logic [SW-1:0]       o_stage,
    output logic [1:0]          o_state,
    output logic                o_retire,
    output logic [CNT_W-1:0]    o_retire_cnt,
    output logic [SW-1:0]       o_fault_stage
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    // The watchdog only ever holds 0..TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int                 WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]    WD_MAX   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SW-1:0]      LAST     = SW'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0] EN_FIRST = N_STAGES'(1);

    state_e               state_q, state_d;
    logic [N_STAGES-1:0]  en_q, en_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic                 retire_q, retire_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]        fault_stage_q, fault_stage_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic                 fin_k;
    logic                 wd_expired;

    // en_q is one-hot in RUN, so this picks out only the enabled stage's finish bit.
    assign fin_k      = |(i_finish & en_q);
    assign wd_expired = (TIMEOUT != 0) && (wdog_q == WD_MAX);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        en_d          = en_q;
        stage_d       = stage_q;
        retire_d      = 1'b0;
        cnt_d         = cnt_q;
        fault_stage_d = fault_stage_q;
        wdog_d        = wdog_q;

        unique case (state_q)
            ST_BOOT: begin
                wdog_d  = '0;
                stage_d = '0;
                if (i_halt_req) begin
                    state_d = ST_HALTED;
                    en_d    = '0;
                end else begin
                    state_d = ST_RUN;
                    en_d    = EN_FIRST;
                end
            end

            ST_RUN: begin
                if (i_flush) begin
                    stage_d = '0;
                    en_d    = EN_FIRST;
                    wdog_d  = '0;
                end else if (wd_expired && !fin_k) begin
                    state_d       = ST_FAULT;
                    en_d          = '0;
                    fault_stage_d = stage_q;
                end else if (fin_k) begin
                    wdog_d = '0;
                    if (stage_q != LAST) begin
                        stage_d = stage_q + SW'(1);
                        en_d    = en_q << 1;
                    end else begin
                        retire_d = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                        stage_d  = '0;
                        if (i_halt_req) begin
                            state_d = ST_HALTED;
                            en_d    = '0;
                        end else begin
                            en_d = EN_FIRST;
                        end
                    end
                end else if ((TIMEOUT != 0) && (wdog_q != WD_MAX)) begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            ST_HALTED: begin
                en_d = '0;
                if (i_resume) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    en_d    = EN_FIRST;
                    wdog_d  = '0;
                end
            end

            ST_FAULT: begin
                en_d = '0;
                if (i_flush) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    en_d    = EN_FIRST;
                    wdog_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q       <= ST_BOOT;
            en_q          <= '0;
            stage_q       <= '0;
            retire_q      <= 1'b0;
            cnt_q         <= '0;
            fault_stage_q <= '0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            stage_q       <= stage_d;
            retire_q      <= retire_d;
            cnt_q         <= cnt_d;
            fault_stage_q <= fault_stage_d;
            wdog_q        <= wdog_d;
        end
    end

    assign o_en          = en_q;
    assign o_stage       = stage_q;
    assign o_state       = state_q;
    assign o_retire      = retire_q;
    assign o_retire_cnt  = cnt_q;
    assign o_fault_stage = fault_stage_q;

    a_en_shape: assert property (@(posedge i_clk) disable iff (i_rst)
        (state_q == ST_RUN) ? $onehot(en_q) : (en_q == '0));

    a_stage_range: assert property (@(posedge i_clk) disable iff (i_rst)
        int'(stage_q) < N_STAGES);

endmodule
